// File: rtl/uart_tx_engine.sv
// uart_tx_engine: serialises the data register low byte as one 8N1 frame on tx_o, then clears the send bit via WR2.
// Optional macro UART_TX_PARITY_EN inserts an even-parity bit between the data bits and the stop bit.
module uart_tx_engine #(
    parameter int CLKS_PER_BIT = 868,
    parameter int CNT_W        = 16
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [31:0] ctrl_reg_i,
    input  logic [31:0] data_reg_i,
    output logic        ctrl_wr_o,
    output logic [31:0] ctrl_data_o,
    output logic        tx_o,
    output logic        busy_o
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP,
        S_DONE
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [2:0]       bit_idx;
    logic [7:0]       shift;
    logic             bit_end;
    logic             unused_data;

`ifdef UART_TX_PARITY_EN
    logic             parity_q;
`endif

    assign bit_end     = (cnt == CNT_LAST);
    assign unused_data = ^data_reg_i[31:8];

    // Write-back follows the live control register so host edits during the frame survive.
    assign ctrl_wr_o   = (state == S_DONE);
    assign ctrl_data_o = ctrl_wr_o ? {ctrl_reg_i[31:1], 1'b0} : 32'd0;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state   <= S_IDLE;
            cnt     <= '0;
            bit_idx <= '0;
            shift   <= '0;
            tx_o    <= 1'b1;
            busy_o  <= 1'b0;
`ifdef UART_TX_PARITY_EN
            parity_q <= 1'b0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    tx_o   <= 1'b1;
                    busy_o <= 1'b0;
                    cnt    <= '0;
                    if (ctrl_reg_i[0]) begin
                        shift  <= data_reg_i[7:0];
`ifdef UART_TX_PARITY_EN
                        parity_q <= ^data_reg_i[7:0];
`endif
                        tx_o   <= 1'b0;
                        busy_o <= 1'b1;
                        state  <= S_START;
                    end
                end
                S_START: begin
                    if (bit_end) begin
                        cnt     <= '0;
                        bit_idx <= '0;
                        tx_o    <= shift[0];
                        state   <= S_DATA;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_DATA: begin
                    if (bit_end) begin
                        cnt   <= '0;
                        shift <= shift >> 1;
                        if (bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                            tx_o  <= parity_q;
                            state <= S_PARITY;
`else
                            tx_o  <= 1'b1;
                            state <= S_STOP;
`endif
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                            tx_o    <= shift[1];
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_PARITY: begin
                    if (bit_end) begin
                        cnt   <= '0;
                        tx_o  <= 1'b1;
                        state <= S_STOP;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_STOP: begin
                    if (bit_end) begin
                        cnt   <= '0;
                        state <= S_DONE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_DONE: begin
                    tx_o   <= 1'b1;
                    busy_o <= 1'b0;
                    state  <= S_IDLE;
                end
                default: begin
                    tx_o   <= 1'b1;
                    busy_o <= 1'b0;
                    state  <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_engine.sv
// Bench for uart_tx_engine: a small control register model sits in front of the DUT and
// every cycle of each frame is compared against a slot-based model of the serial line.
module tb_uart_tx_engine;

    localparam int C = 4;
`ifdef UART_TX_PARITY_EN
    localparam int NSLOTS = 11;
`else
    localparam int NSLOTS = 10;
`endif
    localparam int TOTAL = NSLOTS * C;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] ctrl_q = '0;
    logic [31:0] data_reg = '0;
    logic        host_wr = 1'b0;
    logic [31:0] host_wdata = '0;
    logic [31:0] exp_ctrl = '0;
    logic        ctrl_wr;
    logic [31:0] ctrl_data;
    logic        tx;
    logic        busy;
    int          n_cmp = 0;
    int          n_bad = 0;

    uart_tx_engine #(.CLKS_PER_BIT(C), .CNT_W(16)) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .ctrl_reg_i  (ctrl_q),
        .data_reg_i  (data_reg),
        .ctrl_wr_o   (ctrl_wr),
        .ctrl_data_o (ctrl_data),
        .tx_o        (tx),
        .busy_o      (busy)
    );

    always #5 clk = ~clk;

    // Control register: port 2 (engine clear) has priority over the host port.
    always @(posedge clk) begin
        if (ctrl_wr) ctrl_q <= ctrl_data;
        else if (host_wr) ctrl_q <= host_wdata;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // Line level k cycles after the start bit begins, from the frame layout alone.
    function automatic logic model_tx(input int k, input logic [7:0] b);
        int slot;
        slot = k / C;
        if (slot == 0) return 1'b0;
        if (slot <= 8) return b[slot-1];
`ifdef UART_TX_PARITY_EN
        if (slot == 9) return ^b;
`endif
        return 1'b1;
    endfunction

    // Called at a negedge with the engine idle; returns just after the edge that samples send.
    task automatic start_frame(input logic [7:0] b, input logic [31:0] cv);
        data_reg   = ($urandom() & 32'hFFFF_FF00) | {24'd0, b};
        host_wdata = cv | 32'd1;
        host_wr    = 1'b1;
        exp_ctrl   = cv | 32'd1;
        @(negedge clk);
        host_wr = 1'b0;
        check("pre_busy", busy, 0);
        check("pre_tx", tx, 1);
        @(posedge clk);
    endtask

    // mode 0 plain, 1 data change, 2 host rewrite, 3 host set during DONE, 4 reset
    task automatic run_frame(input logic [7:0] b, input int mode, input int at, input logic [31:0] aux);
        int busy_n;
        busy_n = 0;
        for (int k = 0; k <= TOTAL; k++) begin
            @(negedge clk);
            host_wr = 1'b0;
            if (k < TOTAL) begin
                check("tx", tx, model_tx(k, b));
                check("wr_idle", ctrl_wr, 0);
                check("wdata_idle", ctrl_data, 0);
            end else begin
                check("done_tx", tx, 1);
                check("done_wr", ctrl_wr, 1);
                check("done_wdata", ctrl_data, {exp_ctrl[31:1], 1'b0});
            end
            if (busy) busy_n++;
            if (k == at) begin
                case (mode)
                    1: data_reg = aux;
                    2: begin
                        host_wdata = aux;
                        host_wr    = 1'b1;
                        exp_ctrl   = aux;
                    end
                    3: begin
                        host_wdata = aux;
                        host_wr    = 1'b1;
                    end
                    4: begin
                        rst = 1'b1;
                        @(negedge clk);
                        rst = 1'b0;
                        check("rst_tx", tx, 1);
                        check("rst_busy", busy, 0);
                        check("rst_wr", ctrl_wr, 0);
                        check("rst_wdata", ctrl_data, 0);
                        check("rst_send_kept", ctrl_q, exp_ctrl);
                        return;
                    end
                    default: ;
                endcase
            end
        end
        check("busy_len", busy_n, TOTAL + 1);
        exp_ctrl = {exp_ctrl[31:1], 1'b0};
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            host_wr = 1'b0;
            check("post_busy", busy, 0);
            check("post_tx", tx, 1);
            check("post_wr", ctrl_wr, 0);
            check("post_ctrl", ctrl_q, exp_ctrl);
        end
    endtask

    initial begin
        logic [7:0]  b;
        logic [31:0] cv;
        int          mode;

        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_tx", tx, 1);
        check("reset_busy", busy, 0);
        check("reset_wr", ctrl_wr, 0);
        check("reset_wdata", ctrl_data, 0);
        rst = 1'b0;
        @(negedge clk);

        start_frame(8'hA5, 32'h0);
        run_frame(8'hA5, 0, -1, 0);

        start_frame(8'h5E, 32'h8000_0002);
        run_frame(8'h5E, 0, -1, 0);

        start_frame(8'h3C, 32'h0);
        run_frame(8'h3C, 1, 3 * C + 1, 32'h0000_00FF);

        cv = $urandom() & 32'hFFFF_FFFE;
        start_frame(8'hC3, cv);
        run_frame(8'hC3, 2, $urandom_range(0, TOTAL - 1), $urandom() & 32'hFFFF_FFFE);

        cv = $urandom() & 32'hFFFF_FFFE;
        start_frame(8'h81, cv);
        run_frame(8'h81, 3, TOTAL, $urandom() | 32'd1);

        cv = $urandom() & 32'hFFFF_FFFE;
        start_frame(8'h96, cv);
        run_frame(8'h96, 4, 5 * C + 1, 0);
        @(posedge clk);
        run_frame(8'h96, 0, -1, 0);

        start_frame(8'h07, 32'h0);
        run_frame(8'h07, 0, -1, 0);

        for (int n = 0; n < 6; n++) begin
            b    = 8'($urandom_range(0, 255));
            cv   = $urandom() & 32'hFFFF_FFFE;
            mode = $urandom_range(0, 2);
            start_frame(b, cv);
            if (mode == 1) run_frame(b, 1, $urandom_range(0, TOTAL - 1), $urandom());
            else if (mode == 2) run_frame(b, 2, $urandom_range(0, TOTAL - 1), $urandom() & 32'hFFFF_FFFE);
            else run_frame(b, 0, -1, 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
